// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM arbiter.
// Build option: define RAM_ARB_PERF_EN to add per-requester wait counters.
package ram_arb_pkg;
  localparam int ADSIZE_DEF = 4;
  localparam int DASIZE_DEF = 16;
  localparam int ID_W       = 2;   // enough for up to 4 requesters
  localparam int RET_DEPTH  = 2;   // accept -> rvalid latency in cycles

  typedef enum logic {ARB, OWN} state_e;

  typedef struct packed {
    logic                  we;
    logic [ID_W-1:0]       id;
    logic [ADSIZE_DEF-1:0] addr;
    logic [DASIZE_DEF-1:0] wdata;
  } cmd_t;
endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin picker: first masked requester at or after ptr.
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter int NReq = 2
) (
  input  logic [NReq-1:0] req,
  input  logic [ID_W-1:0] ptr,
  input  logic [NReq-1:0] mask,
  output logic [NReq-1:0] gnt,
  output logic [ID_W-1:0] winner
);
  logic [NReq-1:0] req_m;
  logic [NReq-1:0] sel;
  logic            found;
  int              idx;

  assign req_m = req & mask;

  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int k = 0; k < NReq; k++) begin
      idx = (int'(ptr) + k) % NReq;
      sel = NReq'(1) << idx;
      if (!found && |(req_m & sel)) begin
        found  = 1'b1;
        gnt    = sel;
        winner = ID_W'(idx);
      end
    end
  end
endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM, with locked multi-beat ownership.
// Build option: RAM_ARB_PERF_EN adds wait_cnt (16-bit saturating stall counter per requester).
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADSize = ADSIZE_DEF,
  parameter int DASize = DASIZE_DEF,
  parameter int NReq   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NReq-1:0]        req,
  input  logic [NReq-1:0]        we,
  input  logic [NReq-1:0]        lock,
  input  logic [NReq*ADSize-1:0] addr,
  input  logic [NReq*DASize-1:0] wdata,
  output logic [NReq-1:0]        gnt,
  output logic [NReq-1:0]        rvalid,
  output logic [DASize-1:0]      rdata,
`ifdef RAM_ARB_PERF_EN
  output logic [NReq*16-1:0]     wait_cnt,
`endif
  output logic                   ram_en_read,
  output logic                   ram_en_write,
  output logic [ADSize-1:0]      ram_addr,
  output logic [DASize-1:0]      ram_din,
  input  logic [DASize-1:0]      ram_dout
);
  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d, owner_q, owner_d, win;
  logic [NReq-1:0] mask, gnt_raw;
  logic            accept, win_we, win_lock;
  logic [ADSize-1:0] win_addr;
  logic [DASize-1:0] win_wdata;
  cmd_t            cmd_q, cmd_d;
  logic            cmd_vld_q, cmd_vld_d;
  // Return pipe after the command stage; the command register is stage 0.
  logic [RET_DEPTH-1:1]           ret_vld_q, ret_vld_d;
  logic [RET_DEPTH-1:1][ID_W-1:0] ret_id_q, ret_id_d;

  assign mask = (state_q == OWN) ? (NReq'(1) << owner_q) : '1;

  rr_pick #(.NReq(NReq)) u_pick (
    .req(req), .ptr(ptr_q), .mask(mask), .gnt(gnt_raw), .winner(win)
  );

  assign gnt       = rst ? '0 : gnt_raw;
  assign accept    = |gnt;
  assign win_we    = |(we & gnt);
  assign win_lock  = |(lock & gnt);
  assign win_addr  = ADSize'(addr >> (ADSize * win));
  assign win_wdata = DASize'(wdata >> (DASize * win));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cmd_d     = cmd_q;
    cmd_vld_d = accept;
    if (accept) begin
      ptr_d = (win == ID_W'(NReq - 1)) ? '0 : win + 1'b1;
      case (state_q)
        ARB: if (win_lock) begin
          state_d = OWN;
          owner_d = win;
        end
        OWN: if (!win_lock) state_d = ARB;
        default: state_d = ARB;
      endcase
      cmd_d.we    = win_we;
      cmd_d.id    = win;
      cmd_d.addr  = win_addr;
      cmd_d.wdata = win_we ? win_wdata : '0;
    end
    ret_vld_d    = ret_vld_q;
    ret_id_d     = ret_id_q;
    ret_vld_d[1] = cmd_vld_q & ~cmd_q.we;
    ret_id_d[1]  = cmd_q.id;
    for (int s = 2; s < RET_DEPTH; s++) begin
      ret_vld_d[s] = ret_vld_q[s-1];
      ret_id_d[s]  = ret_id_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB;
      ptr_q     <= '0;
      owner_q   <= '0;
      cmd_q     <= '0;
      cmd_vld_q <= 1'b0;
      ret_vld_q <= '0;
      ret_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cmd_q     <= cmd_d;
      cmd_vld_q <= cmd_vld_d;
      ret_vld_q <= ret_vld_d;
      ret_id_q  <= ret_id_d;
    end
  end

  assign ram_en_write = cmd_vld_q & cmd_q.we;
  assign ram_en_read  = cmd_vld_q & ~cmd_q.we;
  assign ram_addr     = cmd_q.addr;
  assign ram_din      = cmd_q.wdata;
  // RAM output floats when no read was issued, so gate it rather than forward.
  assign rvalid = ret_vld_q[RET_DEPTH-1] ? (NReq'(1) << ret_id_q[RET_DEPTH-1]) : '0;
  assign rdata  = ret_vld_q[RET_DEPTH-1] ? ram_dout : '0;

`ifdef RAM_ARB_PERF_EN
  logic [NReq-1:0][15:0] wait_q, wait_d;

  always_comb begin
    wait_d = wait_q;
    for (int i = 0; i < NReq; i++)
      if (req[i] && !gnt[i] && wait_q[i] != 16'hFFFF) wait_d[i] = wait_q[i] + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) wait_q <= '0;
    else     wait_q <= wait_d;
  end

  assign wait_cnt = wait_q;
`endif
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port 16x16 data RAM between NReq requesters using round-robin arbitration with a req/gnt handshake.
- Registers the winning command and drives the RAM's en_read/en_write/addr/DMin.
- Returns read data to the issuing requester with an rvalid strobe.
- Supports locked multi-beat sequences so one requester can own the RAM across consecutive accesses.

Parameters:
- ADSize, 4, RAM address width
- DASize, 16, RAM data width
- NReq, 2, number of requesters (2..4)

Ports:
- clk  input  1  clock; all logic rises on posedge
- rst  input  1  synchronous, active-high reset
- req  input  NReq  per-requester access request
- we  input  NReq  1=write, 0=read; valid with req
- lock  input  NReq  keep ownership after this beat
- addr  input  NReq*ADSize  flattened per-requester address (requester i at [i*ADSize +: ADSize])
- wdata  input  NReq*DASize  flattened per-requester write data
- gnt  output  NReq  one-hot; beat accepted this cycle (combinational)
- rvalid  output  NReq  one-hot; read data for requester i on rdata
- rdata  output  DASize  read return data
- ram_en_read  output  1  to RAM en_read
- ram_en_write  output  1  to RAM en_write
- ram_addr  output  ADSize  to RAM addr
- ram_din  output  DASize  to RAM DMin
- ram_dout  input  DASize  from RAM DMout; undriven (Z) when no read is issued

Behaviour:
- Handshake: requester holds req/we/lock/addr/wdata stable until gnt=1; beat transfers in the cycle where req[i]&gnt[i]=1. gnt never asserts without req.
- At most one gnt bit is high per cycle.
- FSM state ARB:
  - gnt goes to the first requesting index at or after ptr, wrapping modulo NReq.
  - On accept, ptr <= winner+1 (mod NReq).
  - If lock=1 on the accepted beat, next state is OWN with owner=winner.
- FSM state OWN:
  - Only the owner can be granted; other reqs wait.
  - Accepted owner beat with lock=0 returns the FSM to ARB.
  - Owner deasserting req stalls the FSM in OWN; there is no timeout.
- Command stage (registered): on accept in cycle N, in cycle N+1:
  - ram_en_write=we, ram_en_read=~we
  - ram_addr/ram_din from the winner; ram_din=0 for reads.
  - No accept → both enables 0; addr/din hold their previous value.
- ram_en_read and ram_en_write are never high together.
- Return stage:
  - Read accepted in cycle N gives rvalid[id]=1 in cycle N+2, with rdata=ram_dout.
  - In all other cycles rdata=0; Z from the RAM is never forwarded.
  - Writes produce no rvalid.
- Throughput: one beat per cycle, back-to-back. A read immediately following a write to the same address returns the new data, because the RAM orders them.
- Reset values: gnt=0, rvalid=0, rdata=0, ram_en_read=0, ram_en_write=0, ram_addr=0, ram_din=0, ptr=0, state=ARB.
- Reset mid-operation: in-flight command and pending rvalid are dropped, never delivered. The RAM is cleared by the same rst.
- gnt is forced to 0 during the rst cycle.

Optional Feature:
- Macro: RAM_ARB_PERF_EN
- Defined:
  - Adds output wait_cnt, NReq*16 bits.
  - Per requester, a 16-bit counter increments each cycle req[i]=1 and gnt[i]=0.
  - Saturates at 16'hFFFF; cleared by rst.
- Undefined: port and counters absent; behaviour otherwise identical.

Decomposition:
- Package ram_arb_pkg:
  - state enum {ARB, OWN}
  - cmd_t struct {we, id, addr, wdata}
  - default ADSize/DASize constants
  - localparam for the return-pipeline depth (2)
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, ptr, mask.
  - Outputs: one-hot grant and encoded winner.
  - The top module holds the FSM, ptr, command and return registers.

Test Plan:
- Reset, then req0 write addr 3 data 16'hA5A5 → gnt[0] same cycle; next cycle ram_en_write=1, ram_addr=3, ram_din=A5A5. Later req0 read addr 3 → rvalid[0]=1 two cycles after gnt, rdata=A5A5.
- req0 and req1 held high continuously, reads to addr 0/1 → gnt alternates 0,1,0,1 starting with 0 after reset; each rvalid matches its id.
- req1 locked for 3 beats (lock=1,1,0) while req0 is held high → gnt[1] three consecutive cycles, gnt[0] only after the lock=0 beat.
- Assert rst in the cycle after a read grant → no rvalid ever appears; all outputs 0; next read of any address returns 0.
- Idle cycles with no req → ram_en_read=ram_en_write=0, rdata=0 (never X/Z). Check en_read&&en_write=0 every cycle.
- PERF build: req0 blocked by 5 locked req1 beats → wait_cnt[0]=5; saturation checked by forcing the counter to FFFE, then 3 blocked cycles → FFFF.
